// File: rtl/spi_pwm_master.sv
// SPI master: sends one PACK_LENGTH-bit PWM word per transfer and returns the word read on MISO.
// Optional build macro SPI_MASTER_LOOPBACK_EN samples MOSI internally instead of the MISO pin.
module spi_pwm_master #(
    parameter int unsigned CPHA                       = 1,
    parameter int unsigned CPOL                       = 1,
    parameter int unsigned PACK_LENGTH                = 8,
    parameter int unsigned PACK_BIT_SEQUENCE_TRANSMIT = 1,
    parameter int unsigned PACK_BIT_SEQUENCE_RECEIVE  = 1,
    parameter int unsigned CLOCK_FREQUENCY            = 50000000,
    parameter int unsigned SCLK_FREQUENCY             = 1000000,
    parameter int unsigned CS_GAP_CYCLES              = 4
) (
    input  logic                   IN_CLOCK,
    input  logic                   IN_RESET,
    input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
    input  logic                   IN_VALID,
    output logic                   OUT_READY,
    input  logic                   MISO,
    output logic                   SCLK,
    output logic                   CS,
    output logic                   MOSI,
    output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
    output logic                   OUT_RECEIVE_VALID
);

    localparam int unsigned HALF     = CLOCK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int unsigned EDGES    = 2 * PACK_LENGTH;
    localparam int unsigned GAP_LAST = (CS_GAP_CYCLES > 0) ? CS_GAP_CYCLES - 1 : 0;
    localparam int unsigned CNT_MAX  = (HALF > CS_GAP_CYCLES) ? HALF : CS_GAP_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned EDGE_W   = $clog2(EDGES + 1);
    localparam logic        SCLK_IDLE = (CPOL != 0);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [EDGE_W-1:0]      edge_q, edge_d;
    logic [PACK_LENGTH-1:0] tx_q, tx_d;
    logic [PACK_LENGTH-1:0] rx_q, rx_d;
    logic [PACK_LENGTH-1:0] rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_q, cs_d;
    logic                   mosi_q, mosi_d;
    logic                   ready_q, ready_d;
    logic                   half_done;
    logic                   do_edge;
    logic                   sample_edge;
    logic                   sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = MISO;
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = MISO;
`endif

    function automatic logic tx_first(input logic [PACK_LENGTH-1:0] w);
        return (PACK_BIT_SEQUENCE_TRANSMIT != 0) ? w[PACK_LENGTH-1] : w[0];
    endfunction

    function automatic logic [PACK_LENGTH-1:0] tx_shift(input logic [PACK_LENGTH-1:0] w);
        if (PACK_BIT_SEQUENCE_TRANSMIT != 0) return {w[PACK_LENGTH-2:0], 1'b0};
        return {1'b0, w[PACK_LENGTH-1:1]};
    endfunction

    function automatic logic [PACK_LENGTH-1:0] rx_merge(input logic [PACK_LENGTH-1:0] w,
                                                         input logic                   b);
        if (PACK_BIT_SEQUENCE_RECEIVE != 0) return {w[PACK_LENGTH-2:0], b};
        return {b, w[PACK_LENGTH-1:1]};
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        ready_d     = ready_q;
        do_edge     = 1'b0;
        half_done   = (cnt_q == CNT_W'(HALF - 1));
        // Even edge_q means the upcoming edge is odd-numbered, i.e. leading.
        sample_edge = (CPHA == 0) ? ~edge_q[0] : edge_q[0];

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (IN_VALID && ready_q) begin
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    edge_d  = '0;
                    rx_d    = '0;
                    state_d = StSetup;
                    if (CPHA == 0) begin
                        mosi_d = tx_first(IN_TRANSMIT_DATA);
                        tx_d   = tx_shift(IN_TRANSMIT_DATA);
                    end else begin
                        tx_d   = IN_TRANSMIT_DATA;
                    end
                end
            end
            StSetup: begin
                if (half_done) begin
                    do_edge = 1'b1;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (half_done) begin
                    if (edge_q == EDGE_W'(EDGES)) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        do_edge = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (half_done) begin
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_edge) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            if (sample_edge) begin
                rx_d = rx_merge(rx_q, sample_bit);
            end else if (CPHA != 0 || edge_q != EDGE_W'(EDGES - 1)) begin
                // With CPHA = 0 the final trailing edge leaves the last bit on MOSI.
                mosi_d = tx_first(tx_q);
                tx_d   = tx_shift(tx_q);
            end
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (!IN_RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= SCLK_IDLE;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
        end
    end

    assign OUT_READY         = ready_q;
    assign SCLK              = sclk_q;
    assign CS                = cs_q;
    assign MOSI              = mosi_q;
    assign OUT_RECEIVE_DATA  = rx_data_q;
    assign OUT_RECEIVE_VALID = rx_valid_q;

endmodule
